// File: rtl/uart_tx.sv
// UART 8N1 transmitter with a built-in oversampling tick generator.
// One byte per accepted request, LSB first, line idles high.
module uart_tx #(
    parameter int NB_DATA       = 8,
    parameter int CLKS_PER_TICK = 163,
    parameter int TICKS_PER_BIT = 16,
    parameter int NB_STOP_TICKS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int TMAX  = (TICKS_PER_BIT > NB_STOP_TICKS) ? TICKS_PER_BIT : NB_STOP_TICKS;
    localparam int TCK_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_TICK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TCK_W-1:0] BIT_LAST  = TCK_W'(TICKS_PER_BIT - 1);
    localparam logic [TCK_W-1:0] STOP_LAST = TCK_W'(NB_STOP_TICKS - 1);
    localparam logic [TCK_W-1:0] TCK_ONE   = TCK_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_DATA - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_r,    state_next_s;
    logic [CNT_W-1:0]   cnt_r,      cnt_next_s;
    logic [TCK_W-1:0]   tick_cnt_r, tick_cnt_next_s;
    logic [IDX_W-1:0]   bit_idx_r,  bit_idx_next_s;
    logic [NB_DATA-1:0] shift_r,    shift_next_s;
    logic               tx_r,       tx_next_s;
    logic               busy_r,     busy_next_s;
    logic               done_r,     done_next_s;
    logic               tick_s;

    assign tick_s = (state_r != IDLE) && (cnt_r == CNT_LAST);

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            tick_cnt_r <= '0;
            bit_idx_r  <= '0;
            shift_r    <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            tick_cnt_r <= tick_cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            shift_r    <= shift_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
        end
    end

    // Next-state, tick bookkeeping and next registered line values.
    always_comb begin
        state_next_s    = state_r;
        tick_cnt_next_s = tick_cnt_r;
        bit_idx_next_s  = bit_idx_r;
        shift_next_s    = shift_r;
        tx_next_s       = tx_r;
        busy_next_s     = busy_r;
        done_next_s     = 1'b0;

        if (state_r == IDLE) begin
            cnt_next_s = '0;
        end else if (tick_s) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end

        case (state_r)
            IDLE: begin
                tx_next_s   = 1'b1;
                busy_next_s = 1'b0;
                if (i_tx_start) begin
                    shift_next_s    = i_data;
                    cnt_next_s      = '0;
                    tick_cnt_next_s = '0;
                    bit_idx_next_s  = '0;
                    state_next_s    = START;
                    tx_next_s       = 1'b0;
                    busy_next_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (!tick_s) begin
                    state_next_s = START;
                end else if (tick_cnt_r == BIT_LAST) begin
                    tick_cnt_next_s = '0;
                    bit_idx_next_s  = '0;
                    state_next_s    = DATA;
                    tx_next_s       = shift_r[0];
                end else begin
                    tick_cnt_next_s = tick_cnt_r + TCK_ONE;
                end
            end
            DATA: begin
                if (!tick_s) begin
                    state_next_s = DATA;
                end else if (tick_cnt_r == BIT_LAST) begin
                    tick_cnt_next_s = '0;
                    shift_next_s    = shift_r >> 1;
                    // Last data bit leaves the line high for the stop bit.
                    if (bit_idx_r == IDX_LAST) begin
                        bit_idx_next_s = '0;
                        state_next_s   = STOP;
                        tx_next_s      = 1'b1;
                    end else begin
                        bit_idx_next_s = bit_idx_r + IDX_ONE;
                        tx_next_s      = shift_next_s[0];
                    end
                end else begin
                    tick_cnt_next_s = tick_cnt_r + TCK_ONE;
                end
            end
            STOP: begin
                if (!tick_s) begin
                    state_next_s = STOP;
                end else if (tick_cnt_r == STOP_LAST) begin
                    tick_cnt_next_s = '0;
                    state_next_s    = IDLE;
                    tx_next_s       = 1'b1;
                    busy_next_s     = 1'b0;
                    done_next_s     = 1'b1;
                end else begin
                    tick_cnt_next_s = tick_cnt_r + TCK_ONE;
                end
            end
            default: begin
                state_next_s    = IDLE;
                cnt_next_s      = '0;
                tick_cnt_next_s = '0;
                bit_idx_next_s  = '0;
                tx_next_s       = 1'b1;
                busy_next_s     = 1'b0;
            end
        endcase
    end

    assign o_tx      = tx_r;
    assign o_tx_busy = busy_r;
    assign o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one instance with one stop bit and one with two,
// both at 2 clocks per tick; line waveform compared against a frame-timing model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx #(.NB_DATA(8), .CLKS_PER_TICK(2), .TICKS_PER_BIT(16), .NB_STOP_TICKS(16)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_tx_start(start1), .i_data(data),
        .o_tx(tx1), .o_tx_busy(busy1), .o_tx_done(done1)
    );

    uart_tx #(.NB_DATA(8), .CLKS_PER_TICK(2), .TICKS_PER_BIT(16), .NB_STOP_TICKS(32)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_tx_start(start2), .i_data(data),
        .o_tx(tx2), .o_tx_busy(busy2), .o_tx_done(done2)
    );

    localparam int BIT_CYC = 16 * 2;

    typedef struct {
        logic [7:0] d;
        bit         use2;
        int         len;
        int         poke_a;
        int         poke_b;
    } vec_t;

    vec_t tbl[6];

    // Reference line value k cycles after acceptance: start, 8 data bits, then high.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        if (k < BIT_CYC) return 1'b0;
        if (k < 9 * BIT_CYC) return d[(k - BIT_CYC) / BIT_CYC];
        return 1'b1;
    endfunction

    function automatic int frame_len(input bit use2);
        return (16 * 9 + (use2 ? 32 : 16)) * 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic launch(input logic [7:0] d, input bit use2);
        @(negedge clk);
        data = d;
        if (use2) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the first negedge after acceptance; checks every cycle up to the done pulse.
    task automatic check_frame(input logic [7:0] d, input bit use2, input int len,
                               input int poke_a, input int poke_b, input bit keep_start,
                               input logic [7:0] d_late, output int done_at);
        logic a_tx, a_busy, a_done, s;
        done_at = -1;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            a_tx   = use2 ? tx2 : tx1;
            a_busy = use2 ? busy2 : busy1;
            a_done = use2 ? done2 : done1;
            chk("line", {31'd0, a_tx}, {31'd0, exp_line(d, k)});
            chk("busy", {31'd0, a_busy}, {31'd0, (k < len)});
            chk("done", {31'd0, a_done}, {31'd0, (k == len)});
            if (a_done && done_at < 0) done_at = k;
            s = keep_start || (k == poke_a) || (k == poke_b);
            if (use2) start2 = s; else start1 = s;
            if (k == poke_a || k == poke_b) data = 8'($urandom);
            if (k == 5) data = d_late;
        end
        chk("frame_len", done_at, len);
    endtask

    task automatic post_idle(input bit use2);
        @(negedge clk);
        chk("done_width", {31'd0, use2 ? done2 : done1}, 32'd0);
        chk("idle_line", {31'd0, use2 ? tx2 : tx1}, 32'd1);
        chk("idle_busy", {31'd0, use2 ? busy2 : busy1}, 32'd0);
    endtask

    initial begin
        int da, db, len, pa, pb;
        logic [7:0] d;
        bit u2;

        tbl[0] = '{d: 8'hA5, use2: 1'b0, len: 320, poke_a: -1, poke_b: -1};
        tbl[1] = '{d: 8'h3C, use2: 1'b0, len: 320, poke_a: 50, poke_b: 200};
        tbl[2] = '{d: 8'h00, use2: 1'b1, len: 352, poke_a: -1, poke_b: -1};
        tbl[3] = '{d: 8'hFF, use2: 1'b0, len: 320, poke_a: 10, poke_b: 300};
        tbl[4] = '{d: 8'h5A, use2: 1'b1, len: 352, poke_a: 100, poke_b: 340};
        tbl[5] = '{d: 8'h81, use2: 1'b0, len: 320, poke_a: -1, poke_b: -1};

        // Reset and idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_line", {31'd0, tx1}, 32'd1);
            chk("rst_busy", {31'd0, busy1}, 32'd0);
            chk("rst_done", {31'd0, done1 | done2}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_line", {31'd0, tx1 & tx2}, 32'd1);
            chk("idle_flags", {30'd0, busy1 | busy2, done1 | done2}, 32'd0);
        end

        // Table-driven frames, including busy rejection and two stop bits
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].d, tbl[i].use2);
            check_frame(tbl[i].d, tbl[i].use2, tbl[i].len, tbl[i].poke_a, tbl[i].poke_b,
                        1'b0, 8'($urandom), da);
            post_idle(tbl[i].use2);
        end

        // Back-to-back with start held high and data switched mid-frame
        launch(8'h01, 1'b0);
        check_frame(8'h01, 1'b0, 320, -1, -1, 1'b1, 8'h80, da);
        @(posedge clk);
        @(negedge clk);
        check_frame(8'h80, 1'b0, 320, -1, -1, 1'b0, 8'h80, db);
        chk("b2b_total", da + db, 640);
        post_idle(1'b0);

        // Mid-frame reset during data bit 3, then a clean frame
        launch(8'h55, 1'b0);
        start1 = 1'b0;
        repeat (140) @(negedge clk);
        chk("pre_rst_line", {31'd0, tx1}, {31'd0, exp_line(8'h55, 140)});
        rst_n = 1'b0;
        #1;
        chk("abort_line", {31'd0, tx1}, 32'd1);
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_done", {31'd0, done1}, 32'd0);
            chk("abort_line", {31'd0, tx1}, 32'd1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk("after_rst_done", {31'd0, done1}, 32'd0);
            chk("after_rst_line", {31'd0, tx1}, 32'd1);
        end
        launch(8'hC3, 1'b0);
        check_frame(8'hC3, 1'b0, 320, -1, -1, 1'b0, 8'($urandom), da);
        post_idle(1'b0);

        // Randomized frames with random ignored requests while busy
        for (int i = 0; i < 16; i++) begin
            d   = 8'($urandom);
            u2  = 1'($urandom_range(0, 1));
            len = frame_len(u2);
            pa  = $urandom_range(6, len - 3);
            pb  = $urandom_range(6, len - 3);
            launch(d, u2);
            check_frame(d, u2, len, pa, pb, 1'b0, 8'($urandom), da);
            post_idle(u2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART 8N1 transmitter that serializes one data byte per request onto a single line.
- It is the outbound counterpart of the operand/opcode loading path. The ALU result byte is handed to it and sent to the host, replacing the switch/LED interface.
- It contains its own oversampling tick generator, so it needs no external baud block.

Parameters:
NB_DATA, 8, data bits per frame (LSB first)
CLKS_PER_TICK, 163, i_clk cycles per oversampling tick (50 MHz / 19200 baud / 16)
TICKS_PER_BIT, 16, ticks per start/data bit
NB_STOP_TICKS, 16, ticks in the stop bit (16 = 1 stop bit, 32 = 2)

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous active-low reset
i_tx_start  input  1  request to send i_data; sampled every cycle
i_data  input  NB_DATA  byte to send; captured when the request is accepted
o_tx  output  1  serial line, idles high
o_tx_busy  output  1  high while a frame is in progress
o_tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset: i_clk is the only clock. i_reset is asynchronous and active-low. While i_reset=0, the block is held as follows:
  - state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0;
  - shift register, tick counter, tick count and bit index are all 0.
- Reset may arrive mid-frame. The frame is aborted immediately, o_tx returns to 1, and no o_tx_done is produced.
- States are IDLE, START, DATA and STOP.
- Tick generator:
  - The cycle counter runs only when state != IDLE and is cleared on request acceptance.
  - A tick is asserted in the cycle where counter == CLKS_PER_TICK-1; the counter wraps to 0 at that point.
- IDLE:
  - A request is accepted at an edge where i_tx_start=1 and state=IDLE.
  - At that edge: i_data is latched into the shift register, the tick counters are cleared, and the state moves to START.
  - From the next cycle, o_tx=0 and o_tx_busy=1.
- START: after TICKS_PER_BIT ticks, go to DATA with bit index 0 and drive o_tx = shift[0].
- DATA:
  - Each bit is held for TICKS_PER_BIT ticks, then the register shifts right and the bit index increments.
  - After bit NB_DATA-1, go to STOP with o_tx=1.
- STOP:
  - After NB_STOP_TICKS ticks, go to IDLE.
  - At that same edge o_tx_done pulses high for exactly one cycle and o_tx_busy falls.
- Frame length, from the acceptance edge to the done pulse, is exactly (TICKS_PER_BIT*(1+NB_DATA)+NB_STOP_TICKS)*CLKS_PER_TICK cycles.
- i_tx_start while busy is ignored: no queuing, no effect on the current frame. A later change of i_data while busy is also ignored.
- Back-to-back operation: a request is accepted in the cycle o_tx_done=1, because the state is already IDLE. The new start bit begins with no extra idle bit.
- i_tx_start held high continuously yields continuous frames, each separated only by its own stop bit.
- o_tx, o_tx_busy and o_tx_done are registered outputs with no combinational paths from the inputs.

Test Plan:
1. Reset and idle:
   - Stimulus: hold i_reset=0 for 5 cycles, release, wait 100 cycles with no request.
   - Required: o_tx=1, o_tx_busy=0, o_tx_done=0 throughout.
2. Single frame, with CLKS_PER_TICK=2 and the remaining parameters at default:
   - Stimulus: pulse i_tx_start with i_data=8'hA5.
   - Required: o_tx is low for 32 cycles, then carries bits 1,0,1,0,0,1,0,1 at 32 cycles each, then is high for 32 cycles.
   - Required: o_tx_done pulses once, 320 cycles after acceptance.
3. Busy rejection:
   - Stimulus: start 8'h3C, then assert i_tx_start with i_data=8'hFF at cycle 50 and cycle 200.
   - Required: only 8'h3C is transmitted, and exactly one done pulse occurs.
4. Back-to-back:
   - Stimulus: hold i_tx_start=1, with i_data=8'h01 then 8'h80 (switched while the first frame is busy).
   - Required: the second start bit begins the cycle after the first done pulse.
   - Required: the decoded bytes are 01 then 80, with 640 cycles in total.
5. Mid-frame reset:
   - Stimulus: assert i_reset=0 during data bit 3 of 8'h55, release, then send 8'hC3.
   - Required: o_tx goes to 1 immediately with no done pulse; then 8'hC3 is sent correctly.
6. Two stop bits:
   - Stimulus: NB_STOP_TICKS=32, CLKS_PER_TICK=2, send 8'h00.
   - Required: the stop-high period is 64 cycles, and the done pulse comes 352 cycles after acceptance.
